// File: rtl/fpu_if_pkg.sv
// Shared types for the FPU issue path: FSM state encoding and the canonical quiet NaN.
package fpu_if_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/axis_hold_slot.sv
// One AXIS source channel: latches an operand, holds tvalid/tdata until its own handshake.
module axis_hold_slot #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] data_i,
  input  logic            tready_i,
  output logic            tvalid_o,
  output logic [XLEN-1:0] tdata_o,
  output logic            drained_o
);

  logic            tvalid_q;
  logic [XLEN-1:0] tdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else if (load_i) begin
      tvalid_q <= 1'b1;
      tdata_q  <= data_i;
    end else if (tvalid_q && tready_i) begin
      tvalid_q <= 1'b0;
    end
  end

  assign tvalid_o  = tvalid_q;
  assign tdata_o   = tdata_q;
  // Channel has nothing outstanding after this edge.
  assign drained_o = !tvalid_q || tready_i;

endmodule

// File: rtl/fpu_issue_unit.sv
// Issues three operands to an FMA core over AXIS, waits for the result with a timeout.
module fpu_issue_unit
  import fpu_if_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] dataA_i,
  input  logic [XLEN-1:0] dataB_i,
  input  logic [XLEN-1:0] dataC_i,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_data_o,
  output logic            busy_o,
  output logic            a_tvalid_o,
  output logic [XLEN-1:0] a_tdata_o,
  input  logic            a_tready_i,
  output logic            b_tvalid_o,
  output logic [XLEN-1:0] b_tdata_o,
  input  logic            b_tready_i,
  output logic            c_tvalid_o,
  output logic [XLEN-1:0] c_tdata_o,
  input  logic            c_tready_i,
  input  logic            r_tvalid_i,
  input  logic [XLEN-1:0] r_tdata_i,
  output logic            r_tready_o,
  output logic            ovf_o,
  output logic            timeout_o,
  output logic [31:0]     perf_busy_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   wait_cnt_q;
  logic [XLEN-1:0]   result_q;
  logic              ovf_q, timeout_q;
  logic [31:0]       perf_q;
  logic              load;
  logic              a_drained, b_drained, c_drained, all_drained;
  logic              wait_expired;

  assign load         = (state_q == StIdle) && valid_i;
  assign all_drained  = a_drained && b_drained && c_drained;
  // A real result in the same cycle takes precedence over the timeout.
  assign wait_expired = (state_q == StWait) && !r_tvalid_i &&
                        (wait_cnt_q == CntW'(TIMEOUT - 1));

  axis_hold_slot #(.XLEN(XLEN)) u_slot_a (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .data_i    (dataA_i),
    .tready_i  (a_tready_i),
    .tvalid_o  (a_tvalid_o),
    .tdata_o   (a_tdata_o),
    .drained_o (a_drained)
  );

  axis_hold_slot #(.XLEN(XLEN)) u_slot_b (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .data_i    (dataB_i),
    .tready_i  (b_tready_i),
    .tvalid_o  (b_tvalid_o),
    .tdata_o   (b_tdata_o),
    .drained_o (b_drained)
  );

  axis_hold_slot #(.XLEN(XLEN)) u_slot_c (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .data_i    (dataC_i),
    .tready_i  (c_tready_i),
    .tvalid_o  (c_tvalid_o),
    .tdata_o   (c_tdata_o),
    .drained_o (c_drained)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (valid_i) state_d = StIssue;
      StIssue: if (all_drained) state_d = StWait;
      StWait:  if (r_tvalid_i || wait_expired) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o         = (state_q != StIdle);
    r_tready_o     = (state_q == StWait);
    result_valid_o = (state_q == StDone);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      timeout_q  <= 1'b0;
      perf_q     <= '0;
    end else begin
      if (state_q == StIssue && all_drained) begin
        wait_cnt_q <= '0;
      end else if (state_q == StWait) begin
        wait_cnt_q <= wait_cnt_q + CntW'(1);
      end
      if (state_q == StWait && r_tvalid_i) begin
        result_q <= r_tdata_i;
      end else if (wait_expired) begin
        result_q  <= XLEN'(QNAN);
        timeout_q <= 1'b1;
      end
      if (valid_i && state_q != StIdle) begin
        ovf_q <= 1'b1;
      end
      if (busy_o && perf_q != 32'hFFFF_FFFF) begin
        perf_q <= perf_q + 32'd1;
      end
    end
  end

  assign result_data_o = result_q;
  assign ovf_o         = ovf_q;
  assign timeout_o     = timeout_q;
  assign perf_busy_o   = perf_q;

endmodule

// File: doc/fpu_issue_unit.md
FPU_ISSUE_UNIT -- requirements
Module: fpu_issue_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, which sets the operand and result width.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, which is the maximum number of WAIT cycles before abort.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk_i  in  1  single clock; all logic on posedge.
- rst_i  in  1  reset, asynchronous and active-high.
- valid_i  in  1  one-cycle operand-issue pulse from the data feeder.
- dataA_i / dataB_i / dataC_i  in  XLEN  operands, sampled when valid_i is high.
- result_valid_o  out  1  one-cycle pulse when the result is available.
- result_data_o  out  XLEN  last result, held until the next result.
- busy_o  out  1  high whenever the state is not IDLE.
- a_tvalid_o, a_tdata_o[XLEN], a_tready_i  AXIS source for operand A toward the FMA core.
- b_tvalid_o, b_tdata_o[XLEN], b_tready_i  AXIS source for operand B.
- c_tvalid_o, c_tdata_o[XLEN], c_tready_i  AXIS source for operand C.
- r_tvalid_i, r_tdata_i[XLEN]  in; r_tready_o  out  AXIS sink for the result.
- ovf_o  out  1  sticky flag: valid_i arrived while busy.
- timeout_o  out  1  sticky flag: WAIT exceeded TIMEOUT.
- perf_busy_o  out  32  saturating count of non-IDLE cycles.

Function
REQ-004 The FSM SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-005 In IDLE, valid_i=1 SHALL latch A, B and C into the tdata registers and move to ISSUE on the next edge.
REQ-006 In ISSUE, each x_tvalid_o SHALL stay high until its own x_tready_i handshake occurs; each channel then drops its tvalid independently.
- tdata SHALL stay stable while tvalid is high.
REQ-007 The FSM SHALL move from ISSUE to WAIT on the edge where the last outstanding channel handshakes; channels may complete in any order or simultaneously.
REQ-008 r_tready_o SHALL be 1 only in WAIT.
- On r_tvalid_i=1, r_tdata_i SHALL be captured into result_data_o and the FSM SHALL move to DONE.
REQ-009 In DONE, result_valid_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-010 Best-case latency SHALL be: valid_i at cycle 0, tvalids high at cycle 1, WAIT at cycle 2; a result handshake at cycle k gives result_valid_o at cycle k+1.
REQ-011 A WAIT counter SHALL clear on entry to WAIT and increment each WAIT cycle.
- On reaching TIMEOUT-1 with no result: set timeout_o, load result_data_o with 32'h7FC0_0000 (qNaN), go to DONE.
REQ-012 valid_i in any state other than IDLE (including DONE) SHALL be ignored for issue and SHALL set ovf_o; the operand registers SHALL remain unchanged.
REQ-013 ovf_o and timeout_o SHALL be sticky and SHALL be cleared only by reset.
REQ-014 perf_busy_o SHALL increment on every cycle in which busy_o=1 and SHALL saturate at 32'hFFFF_FFFF.
REQ-015 If r_tvalid_i and the timeout condition occur in the same cycle, the real result SHALL win and timeout_o SHALL stay unchanged.

Reset
REQ-016 On rst_i=1, all of the following SHALL be cleared immediately and asynchronously: state=IDLE, all tvalid/tready outputs=0, result_valid_o=0, result_data_o=0, operand registers=0, ovf_o=0, timeout_o=0, perf_busy_o=0, WAIT counter=0.
REQ-017 Reset asserted mid-transaction SHALL abandon the transaction with no result_valid_o pulse.
REQ-018 The first valid_i after reset deassertion SHALL be accepted normally.

Structure
REQ-019 The state encoding type and the QNAN constant SHALL live in shared package fpu_if_pkg.
REQ-020 The per-channel tvalid/tdata hold logic SHALL be one sub-module, axis_hold_slot, instantiated three times (A, B, C).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- All treadys tied 1; A=3F80_0000, B=4000_0000, C=4040_0000; r_tvalid at cycle 5 with 40A0_0000 -> result_valid_o pulse at cycle 6, result_data_o=40A0_0000.
- a_tready delayed 3 cycles, c_tready delayed 1, b_tready immediate -> each tvalid drops at its own handshake; WAIT entered the edge after the A handshake.
- Second valid_i while in WAIT -> ovf_o=1, in-flight result unchanged, exactly one result_valid_o pulse.
- r_tvalid_i never asserted, TIMEOUT=16 -> timeout_o=1, result_data_o=7FC0_0000, result_valid_o pulse, return to IDLE.
- rst_i asserted during ISSUE -> all tvalids low immediately, no result pulse; next transaction completes correctly.
- 10 back-to-back transactions -> perf_busy_o equals the summed non-IDLE cycles.
